// File: rtl/uart_pkg.sv
// uart_pkg: encodings, widths and receiver states shared by uart_rx and uart_tx
package uart_pkg;
   localparam int DATA_W = 8;
   localparam logic [1:0] PAR_NONE   = 2'b00;
   localparam logic [1:0] PAR_EVEN_A = 2'b01;
   localparam logic [1:0] PAR_EVEN_B = 2'b10;
   localparam logic [1:0] PAR_ODD    = 2'b11;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: host-side result and acknowledge signals of the UART receiver
interface uart_rx_if;
   import uart_pkg::*;
   logic read;
   logic full;
   logic [DATA_W-1:0] rx_data;
   logic parity_err;
   logic frame_err;
   logic overrun;
   logic busy;
   modport master(output read, input full, rx_data, parity_err, frame_err, overrun, busy);
   modport slave(input read, output full, rx_data, parity_err, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser of the rx line plus falling-edge detect
module uart_rx_sync (
   input  logic clk,
   input  logic rstn,
   input  logic enable,
   input  logic rx,
   output logic rx_s,
   output logic fall
);
   logic [2:0] q;
   always_ff @(posedge clk)
      if (!rstn) q <= '1;
      else if (enable) q <= {q[1:0], rx};
   // q[2] only remembers the previous synchronised value for edge detection
   assign rx_s = q[1];
   assign fall = q[2] & ~q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART frame receiver holding the byte and status flags until acknowledged
module uart_rx
   import uart_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        enable,
   input  logic        rx,
   input  logic [31:0] div,
   input  logic [1:0]  parity,
   uart_rx_if.slave    host
);
   rx_state_t state, state_n;
   logic [31:0] cnt, cnt_n, reload;
   logic [2:0] bitn, bitn_n;
   logic [DATA_W-1:0] sr, sr_n;
   logic perr, perr_n, read_d, rd_edge, commit, tick, rx_s, fall;
   uart_rx_sync u_sync (.clk(clk), .rstn(rstn), .enable(enable), .rx(rx), .rx_s(rx_s), .fall(fall));
   assign tick = cnt == '0;
   assign reload = {div[30:0], 1'b1};
   assign rd_edge = host.read & ~read_d;
   assign host.busy = state != IDLE;
   always_comb begin
      state_n = state;
      cnt_n = tick ? cnt : cnt - 32'd1;
      bitn_n = bitn;
      sr_n = sr;
      perr_n = perr;
      commit = 1'b0;
      case (state)
         IDLE: if (fall) begin
            state_n = START;
            cnt_n = div;
         end
         START: if (tick) begin
            state_n = rx_s ? IDLE : DATA;
            cnt_n = reload;
            bitn_n = '0;
         end
         DATA: if (tick) begin
            sr_n[bitn] = rx_s;
            cnt_n = reload;
            bitn_n = bitn + 3'd1;
            if (bitn == 3'd7) state_n = parity == PAR_NONE ? STOP : PARITY;
         end
         PARITY: if (tick) begin
            perr_n = rx_s ^ (^sr) ^ (parity == PAR_ODD);
            cnt_n = reload;
            state_n = STOP;
         end
         STOP: if (tick) begin
            commit = 1'b1;
            state_n = rx_s ? IDLE : BREAK;
         end
         BREAK: if (rx_s) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!rstn) begin
         state <= IDLE;
         cnt <= '0;
         bitn <= '0;
         sr <= '0;
         perr <= 1'b0;
         read_d <= 1'b0;
         host.full <= 1'b0;
         host.rx_data <= '0;
         host.parity_err <= 1'b0;
         host.frame_err <= 1'b0;
         host.overrun <= 1'b0;
      end else if (enable) begin
         state <= state_n;
         cnt <= cnt_n;
         bitn <= bitn_n;
         sr <= sr_n;
         perr <= perr_n;
         read_d <= host.read;
         // a commit beats a simultaneous read edge, which still suppresses overrun
         host.full <= commit | (host.full & ~rd_edge);
         host.overrun <= (commit & host.full & ~rd_edge) | (host.overrun & ~rd_edge);
         if (commit) begin
            host.rx_data <= sr;
            host.parity_err <= (parity != PAR_NONE) & perr;
            host.frame_err <= ~rx_s;
         end
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with directed frames and a serial line model
module tb_uart_rx;
   import uart_pkg::*;
   typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
   logic clk = 1'b0;
   logic rstn, enable, rx;
   logic [31:0] div;
   logic [1:0] parity;
   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   logic full_prev = 1'b0;
   logic busy_seen = 1'b0;
   uart_rx_if host();
   uart_rx dut (.clk(clk), .rstn(rstn), .enable(enable), .rx(rx), .div(div), .parity(parity), .host(host));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, want);
      end
   endtask
   always @(negedge clk) begin
      if (host.busy) busy_seen = 1'b1;
      if (host.full && !full_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame got %0h want none", host.rx_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rx_data", host.rx_data, e.d);
            chk("parity_err", host.parity_err, e.pe);
            chk("frame_err", host.frame_err, e.fe);
         end
      end
      full_prev = host.full;
   end
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [7:0] d, input logic pe, input logic fe);
      exp_q.push_back('{d: d, pe: pe, fe: fe});
   endtask
   task automatic pulse_read();
      host.read = 1'b1;
      cyc(1);
      host.read = 1'b0;
      cyc(1);
   endtask
   // rd=1 raises read so its edge lands on the same clock as the stop-bit commit
   task automatic send(input logic [7:0] d, input logic has_p, input logic pb, input logic stop, input logic rd);
      int bp;
      bp = 2 * (int'(div) + 1);
      rx = 1'b0;
      cyc(bp);
      for (int k = 0; k < 8; k++) begin
         rx = d[k];
         cyc(bp);
      end
      if (has_p) begin
         rx = pb;
         cyc(bp);
      end
      rx = stop;
      for (int i = 0; i < bp; i++) begin
         cyc(1);
         if (rd && i == 2 + int'(div)) host.read = 1'b1;
         if (rd && i == 3 + int'(div)) host.read = 1'b0;
      end
      rx = 1'b1;
   endtask
   task automatic take();
      int n;
      n = 0;
      while (!host.full && n < 1000) begin
         cyc(1);
         n++;
      end
      if (!host.full) begin
         checks++;
         errors++;
         $display("FAIL full_timeout got 0 want 1");
      end
      pulse_read();
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end
   initial begin
      logic [7:0] b;
      rstn = 1'b0;
      enable = 1'b1;
      rx = 1'b1;
      div = 32'd3;
      parity = PAR_NONE;
      host.read = 1'b0;
      cyc(3);
      chk("rst_full", host.full, 0);
      chk("rst_rx_data", host.rx_data, 0);
      chk("rst_busy", host.busy, 0);
      chk("rst_overrun", host.overrun, 0);
      chk("rst_errs", {host.parity_err, host.frame_err}, 0);
      rstn = 1'b1;
      cyc(4);
      push(8'hA5, 1'b0, 1'b0);
      send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t1_full", host.full, 1);
      chk("t1_busy", host.busy, 0);
      pulse_read();
      chk("t1_full_clr", host.full, 0);
      cyc(4);
      parity = PAR_EVEN_A;
      push(8'h03, 1'b0, 1'b0);
      send(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
      take();
      push(8'h03, 1'b1, 1'b0);
      send(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
      take();
      parity = PAR_ODD;
      push(8'h03, 1'b0, 1'b0);
      send(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
      take();
      parity = PAR_EVEN_B;
      push(8'h07, 1'b0, 1'b0);
      send(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
      take();
      parity = PAR_NONE;
      cyc(4);
      busy_seen = 1'b0;
      rx = 1'b0;
      cyc(3);
      rx = 1'b1;
      cyc(20);
      chk("t3_busy_pulse", busy_seen, 1);
      chk("t3_busy", host.busy, 0);
      chk("t3_full", host.full, 0);
      push(8'h55, 1'b0, 1'b1);
      send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      rx = 1'b0;
      cyc(40);
      chk("t4_break_busy", host.busy, 1);
      chk("t4_full", host.full, 1);
      rx = 1'b1;
      cyc(4);
      chk("t4_idle", host.busy, 0);
      pulse_read();
      push(8'h12, 1'b0, 1'b0);
      send(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
      take();
      cyc(4);
      push(8'h11, 1'b0, 1'b0);
      send(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(4);
      send(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_overrun", host.overrun, 1);
      chk("t5_rx_data", host.rx_data, 8'h22);
      chk("t5_full", host.full, 1);
      pulse_read();
      chk("t5_full_clr", host.full, 0);
      chk("t5_overrun_clr", host.overrun, 0);
      push(8'h33, 1'b0, 1'b0);
      send(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(4);
      send(8'h44, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(2);
      chk("t5_coinc_full", host.full, 1);
      chk("t5_coinc_overrun", host.overrun, 0);
      chk("t5_coinc_data", host.rx_data, 8'h44);
      pulse_read();
      enable = 1'b0;
      rx = 1'b0;
      cyc(30);
      chk("en_frozen_busy", host.busy, 0);
      rx = 1'b1;
      cyc(5);
      enable = 1'b1;
      cyc(20);
      chk("en_busy", host.busy, 0);
      chk("en_full", host.full, 0);
      div = 32'd0;
      cyc(4);
      rx = 1'b0;
      cyc(2);
      rx = 1'b1;
      cyc(4);
      chk("t6_midframe_busy", host.busy, 1);
      rstn = 1'b0;
      cyc(2);
      rstn = 1'b1;
      cyc(1);
      chk("t6_rst_busy", host.busy, 0);
      chk("t6_rst_full", host.full, 0);
      cyc(20);
      for (int n = 0; n < 256; n++) begin
         b = 8'($urandom_range(0, 255));
         push(b, 1'b0, 1'b0);
         send(b, 1'b0, 1'b0, 1'b1, 1'b0);
         take();
         cyc(2);
      end
      div = 32'd100;
      cyc(4);
      for (int n = 0; n < 6; n++) begin
         b = 8'($urandom_range(0, 255));
         push(b, 1'b0, 1'b0);
         send(b, 1'b0, 1'b0, 1'b1, 1'b0);
         take();
         cyc(2);
      end
      cyc(10);
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
